shake256_squeeze_out: RTL
=========================

# shake256_squeeze_out

Output-side streamer for the SHAKE256 core. When the control unit raises `squeeze`, this block captures the 1088-bit rate portion of the Keccak state and emits it as 64-bit words over a valid/ready stream. When a rate block is exhausted and more output is still owed, it requests another permutation over a req/done handshake. It is the reader/drain counterpart to the absorb-side control unit and sits between the state register and the output port of the hash top level.

## Interface
- `WORD_W`, 64: output word width in bits; lane width of the state.
- `RATE_W`, 1088: rate width in bits. `RATE_W/WORD_W` = 17 words per block.
- `LEN_W`, 12: width of the requested-length field, in words.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `squeeze`  in  1  level from the control unit; a rising edge starts a squeeze session.
- `rate_in`  in  1088  rate part of the state. Word i is `rate_in[64*i+63 : 64*i]`.
- `out_words`  in  12  number of 64-bit words to emit; sampled at start.
- `perm_done`  in  1  one-cycle pulse; `rate_in` holds the new state in that same cycle.
- `dout_ready`  in  1  downstream accepts a word.
- `dout`  out  64  current output word.
- `dout_valid`  out  1  `dout` is valid.
- `dout_last`  out  1  high together with `dout_valid` on the final word.
- `perm_req`  out  1  one-cycle pulse requesting one further Keccak-f permutation.
- `busy`  out  1  session in progress (STREAM or PERM).
- `done`  out  1  all requested words have been transferred.

## Operation
- **Registers**
  - 1088-bit block buffer.
  - Word index `idx`: 5 bits, 0..16.
  - Remaining-word counter `rem`: 12 bits.
  - Delayed copy of `squeeze` for edge detection.
- **States:** IDLE, STREAM, PERM, DONE.
- **IDLE**
  - On `squeeze`=1 with the delayed copy 0: latch `rate_in` into the buffer, `rem`=`out_words`, `idx`=0.
  - Go to STREAM, or to DONE if `out_words`=0.
  - Otherwise stay in IDLE.
- **STREAM**
  - `dout` = buffer word `idx`; `dout_valid`=1; `dout_last` = (`rem`==1).
  - On `dout_valid`&`dout_ready`: `rem`--, `idx`++.
  - If `rem` was 1, go to DONE.
  - Else if `idx` was 16, go to PERM and assert `perm_req` for exactly one cycle.
  - Without `dout_ready`, `dout`, `dout_valid` and `dout_last` hold stable.
- **PERM**
  - `dout_valid`=0; wait for `perm_done`.
  - On `perm_done`: latch `rate_in`, `idx`=0, go to STREAM.
- **DONE**
  - `done`=1; hold until `squeeze`=0, then go to IDLE.
  - A new session requires a fresh rising edge of `squeeze`.
- **Abort:** if `squeeze` falls while in STREAM or PERM, go to IDLE next cycle. Outputs drop and no further `perm_req` is issued.
- `perm_done` outside PERM is ignored.
- Counter arithmetic is unsigned. `rem` never underflows because the transition to DONE occurs on the `rem`==1 transfer.
- The maximum session is 4095 words, requiring 240 permutations.

## Timing
- **Reset values:** state=IDLE; `dout`=0; `dout_valid`, `dout_last`, `perm_req`, `busy`, `done` = 0; `idx`=0; `rem`=0; delayed `squeeze`=0. Reset asserted mid-session aborts with no further output.
- **Start latency:** `squeeze` rising edge sampled at clock edge n → `dout_valid`=1 with word 0 after edge n, i.e. visible in cycle n+1.
- **Throughput:** one word per cycle while `dout_ready` is held high.
- **Permutation request:** word 16 accepted at edge k → `perm_req` high for the cycle after edge k, and `dout_valid` is low from that cycle.
- **Resume:** `perm_done` sampled at edge m → word 0 of the new block is valid after edge m.
- `perm_done` arriving in the same cycle as `perm_req` is legal and is honoured only once the block is in PERM, i.e. from the cycle after the `perm_req` edge.
- **Completion:** final word accepted at edge f → `dout_valid`=0 and `done`=1 after edge f.
- `busy` = state ∈ {STREAM, PERM}; it is registered and tracks state.

## Test plan
- **Single word:** `rate_in` word0 = 0x0123456789ABCDEF, `out_words`=1, rise `squeeze`, `dout_ready`=1 → one beat of 0x0123456789ABCDEF with `dout_last`=1; `done`=1 next cycle; `perm_req` never pulses.
- **Exactly one block:** `out_words`=17, word i = i → 17 consecutive beats 0..16, `dout_last` on beat 16, no `perm_req`, then `done`.
- **Multi-block:** `out_words`=20.
  - Words 0..16 are sent, then one `perm_req` pulse.
  - Drive `perm_done` 5 cycles later with `rate_in` word i = 0x100+i → beats 0x100..0x102, `dout_last` on 0x102.
- **Backpressure:** `out_words`=4, toggle `dout_ready` 1,0,0,1,0,1,1 → `dout` stable during stalls, words in order 0..3, exactly 4 transfers.
- **Edge cases:** `out_words`=0 → DONE directly with no beats. Keep `squeeze` high after `done` → no restart; drop and re-raise it → a new session.
- **Abort:** drop `squeeze` in PERM → IDLE, no beats emitted after a later `perm_done`. Assert `reset` mid-STREAM → all outputs 0 immediately.

Source files
------------

// File: rtl/shake256_squeeze_out.sv
// -----------------------------------------------------------------------------
// shake256_squeeze_out
//
// Output-side streamer for the SHAKE256 core. A rising edge on `squeeze`
// snapshots the rate part of the Keccak state and streams it out as WORD_W-bit
// words over a valid/ready interface. When all words of a rate block are sent
// and more output is still owed, one further permutation is requested with a
// single-cycle `perm_req`. The new rate is taken on `perm_done`.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : asynchronous, active-high reset
//   squeeze     : session level; a rising edge starts a session, a fall aborts
//   rate_in     : rate part of the state, word i at [WORD_W*i +: WORD_W]
//   out_words   : number of words to emit, sampled at session start
//   perm_done   : one-cycle pulse, rate_in holds the new state in that cycle
//   dout_ready  : downstream accepts the current word
//   dout        : current output word (0 while not valid)
//   dout_valid  : dout is valid
//   dout_last   : final word of the session
//   perm_req    : one-cycle request for another permutation
//   busy        : session in progress (streaming or waiting for permutation)
//   done        : all requested words transferred, held until squeeze falls
// -----------------------------------------------------------------------------
module shake256_squeeze_out #(
  parameter int WORD_W = 64,
  parameter int RATE_W = 1088,
  parameter int LEN_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squeeze,
  input  logic [RATE_W-1:0] rate_in,
  input  logic [LEN_W-1:0]  out_words,
  input  logic              perm_done,
  input  logic              dout_ready,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              perm_req,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = RATE_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PERM   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [RATE_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                sq_dly_q;

  logic [WORD_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                preq_q, preq_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sq_rise_s;
  logic                xfer_s;
  logic [IDX_W-1:0]    idx_inc_s;
  logic [WORD_W-1:0]   word_sel_s;

  assign sq_rise_s = squeeze & ~sq_dly_q;
  assign xfer_s    = valid_q & dout_ready;
  // idx stays within the block; wrapping only happens when leaving STREAM
  assign idx_inc_s = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));

  // Next-state logic for the session FSM and its counters/buffer.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    preq_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sq_rise_s) begin
          buf_d = rate_in;
          rem_d = out_words;
          idx_d = {IDX_W{1'b0}};
          if (out_words == {LEN_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!squeeze) begin
          state_d = ST_IDLE;
        end else if (xfer_s) begin
          rem_d = rem_q - LEN_W'(1);
          idx_d = idx_inc_s;
          // The rem==1 check comes first so a session ending exactly on a
          // block boundary does not request a useless permutation.
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_PERM;
            preq_d  = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_PERM: begin
        if (!squeeze) begin
          state_d = ST_IDLE;
        end else if (perm_done) begin
          buf_d   = rate_in;
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_STREAM;
        end else begin
          state_d = ST_PERM;
        end
      end
      ST_DONE: begin
        if (!squeeze) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word multiplexer on the next buffer/index so dout can be registered.
  always_comb begin
    word_sel_s = {WORD_W{1'b0}};
    for (int w = 0; w < NWORDS; w++) begin
      word_sel_s = word_sel_s |
                   (buf_d[w*WORD_W +: WORD_W] & {WORD_W{idx_d == IDX_W'(w)}});
    end
  end

  // Output values derived from the next state, registered below.
  always_comb begin
    valid_d = (state_d == ST_STREAM);
    dout_d  = valid_d ? word_sel_s : {WORD_W{1'b0}};
    last_d  = valid_d && (rem_d == LEN_W'(1));
    busy_d  = (state_d == ST_STREAM) || (state_d == ST_PERM);
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      buf_q    <= {RATE_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      rem_q    <= {LEN_W{1'b0}};
      sq_dly_q <= 1'b0;
      dout_q   <= {WORD_W{1'b0}};
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      preq_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      sq_dly_q <= squeeze;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      preq_q   <= preq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign perm_req   = preq_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
